serial_parity_receiver: RTL and testbench
=========================================

# serial_parity_receiver

Receive-side counterpart of the serial parity transmitter. It deserialises the single-wire frame (idle-high line, start bit 0, 8 data bits LSB-first, even-parity bit, stop bit 1) at one bit per `clk` cycle. It presents each received byte on a parallel bus with a valid/ready handshake. Parity, framing and overrun errors are flagged, and the receiver resynchronises after line faults.

## Interface
- `DATA_BITS`, default 8: number of payload bits per frame.
- `clk`  in  1: single clock; the line is sampled on the rising edge, one bit per cycle.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data`  in  1: serial line. Idle is 1; X or Z is treated as idle.
- `bus`  out  DATA_BITS: received byte, held stable while `valid`=1.
- `valid`  out  1: byte available; held until accepted.
- `ready`  in  1: consumer accepts `bus` when `valid`&&`ready` on a rising edge.
- `parity_err`  out  1: parity mismatch for the byte currently on `bus`; qualified by `valid`.
- `frame_err`  out  1: one-cycle pulse when a stop bit samples 0.
- `overrun`  out  1: sticky flag, set when a good frame is dropped because `valid` was still pending. Cleared by a handshake.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE:
  - `data`==0 sampled: go to DATA, clear bit counter and parity accumulator.
  - `data`==1 or X: stay in IDLE.
- DATA:
  - Each cycle, shift the sampled bit into position `bit_cnt` (LSB first) and XOR it into the accumulator.
  - After the DATA_BITS-th sample, go to PARITY.
- PARITY: sample the parity bit; mismatch = sample XOR accumulator. Go to STOP.
- STOP, sample 1 (good frame):
  - If `valid`==0, or `valid`&&`ready` on this same edge: load `bus` and `parity_err`, set `valid`.
  - Otherwise discard the frame and set `overrun`.
  - Go to IDLE.
- STOP, sample 0: pulse `frame_err`, discard the frame, go to BREAK.
- BREAK: wait for `data`==1, then go to IDLE. A held-low line therefore never creates back-to-back false starts.
- Handshake:
  - `valid`&&`ready` clears `valid` and `overrun`, unless a new frame loads on the same edge; in that case `valid` stays 1 with the new byte.
  - `bus` holds its last accepted value after `valid` drops.
- Parity is even over data plus parity bit (sum of the 9 bits is even), identical to the transmitter's XOR of bus[0..7].

## Timing
- Reset values: all outputs 0 (`bus`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0). State is IDLE, counters 0.
- Reset mid-frame aborts the frame with no flags; reception resumes at the next 1→0 edge after release.
- Frame length is 2+DATA_BITS+1 = 11 samples. If the start bit is sampled at edge E0, data is sampled at E1–E8, parity at E9 and stop at E10.
- Latency: `bus`/`valid`/`parity_err` update on E10 and are visible in the cycle after E10. `frame_err` is high for exactly the cycle after E10.
- Back-to-back frames: a start bit may be sampled at E11. No idle gap is required.
- Consumer with `ready` tied to 1: each byte is visible for exactly one cycle.
- Simultaneous load and accept: the new byte wins and `overrun` is not set.

## Structure
- Shared package `serial_pkg`:
  - state enum `rx_state_t`;
  - constants `START_BIT`=0, `STOP_BIT`=1, `IDLE_LEVEL`=1, `FRAME_LEN`;
  - function `even_parity(byte)`, also usable by the transmitter and the benches.
- One natural sub-module: `rx_shift_parity`, a DATA_BITS shift register with a running XOR and a load/clear interface. The FSM, handshake and flags stay in the top module.

## Test plan
- 0xA5, correct parity 0: line 0,1,0,1,0,0,1,0,1,0,1 → `bus`=0xA5, `valid`=1 after E10, `parity_err`=0.
- 0x01 sent with parity bit 0 (should be 1) → `bus`=0x01, `valid`=1, `parity_err`=1.
- 0x3C sent with stop bit 0, then line held low for 20 cycles, then high, then 0x5A → one `frame_err` pulse, no `valid` for 0x3C, no false frames during the low period, 0x5A received correctly.
- `ready`=0, frames 0x11 then 0x22 back-to-back → `bus` stays 0x11 and `overrun`=1. Raise `ready` → `valid` and `overrun` clear.
- `ready` pulsed at exactly E10 of a second frame 0x77 while 0x66 is pending → 0x66 accepted, `bus`=0x77 next cycle, `valid` stays 1, `overrun`=0.
- `rst_n` asserted at E5 of a frame, then released → all outputs 0 and no `valid`. The next clean frame 0xC3 is received correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the single-wire parity link.
// Frame: start(0), DATA_BITS payload bits LSB-first, even-parity bit, stop(1).
// Contents: receiver state enum, line-level constants, frame length and an
// even-parity helper usable by both ends of the link.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int FRAME_LEN = DEFAULT_DATA_BITS + 3;

  // Parity bit that makes the total number of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/serial_parity_receiver_shift.sv
// rx_shift_parity: payload deserialiser with running XOR.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   clear        zero the shift register and the parity accumulator
//   shift        shift bit_in in (LSB-first frame, so new bits enter at MSB)
//   bit_in       sampled line bit
//   shreg        assembled payload; valid after DATA_BITS shifts
//   acc          XOR of all bits shifted in since the last clear
module rx_shift_parity
  import serial_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 shift,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] shreg,
  output logic                 acc
);

  // Shifting right with insertion at the MSB lands the first received bit
  // at index 0 once all DATA_BITS have arrived.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      acc   <= 1'b0;
    end else if (clear) begin
      shreg <= '0;
      acc   <= 1'b0;
    end else if (shift) begin
      if (DATA_BITS > 1) begin
        shreg <= {bit_in, shreg[DATA_BITS-1:1]};
      end else begin
        shreg <= bit_in;
      end
      acc <= acc ^ bit_in;
    end
  end

endmodule

// File: rtl/serial_parity_receiver.sv
// serial_parity_receiver: single-wire frame receiver with valid/ready output.
// Ports:
//   clk         clock; line sampled on every rising edge (one bit per cycle)
//   rst_n       async active-low reset
//   data        serial line, idle high; X/Z treated as idle
//   bus         received payload, stable while valid
//   valid       payload pending; held until valid && ready
//   ready       consumer accept
//   parity_err  parity mismatch for the payload on bus
//   frame_err   one-cycle pulse when a stop bit samples 0
//   overrun     sticky: a good frame was dropped while valid was pending
//
// state  | meaning
// IDLE   | waiting for a start bit (line low)
// DATA   | sampling payload bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit; deliver, drop or flag framing error
// BREAK  | line held low after a framing error; wait for it to go high
module serial_parity_receiver
  import serial_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data,
  output logic [DATA_BITS-1:0] bus,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_BITS - 1);

  rx_state_t state, state_nx;

  logic                 line_bit;
  logic [CNT_W-1:0]     bits_left;
  logic                 sh_clear;
  logic                 sh_shift;
  logic                 perr_cap;
  logic                 load;
  logic                 drop;
  logic                 ferr_set;
  logic                 accept;
  logic                 perr_pend;
  logic [DATA_BITS-1:0] shreg;
  logic                 acc;

  // Only a definite 0 counts as low, so a floating or unknown line never
  // starts a frame.
  assign line_bit = (data === START_BIT) ? START_BIT : IDLE_LEVEL;

  assign accept = valid && ready;

  rx_shift_parity #(
    .DATA_BITS(DATA_BITS)
  ) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (sh_clear),
    .shift (sh_shift),
    .bit_in(line_bit),
    .shreg (shreg),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sh_clear = 1'b0;
    sh_shift = 1'b0;
    perr_cap = 1'b0;
    load     = 1'b0;
    drop     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        if (line_bit == START_BIT) begin
          sh_clear = 1'b1;
          state_nx = DATA;
        end
      end
      DATA: begin
        sh_shift = 1'b1;
        if (bits_left == '0) begin
          state_nx = PARITY;
        end
      end
      PARITY: begin
        perr_cap = 1'b1;
        state_nx = STOP;
      end
      STOP: begin
        if (line_bit == STOP_BIT) begin
          // A consumer accepting on this same edge frees the slot.
          if (!valid || ready) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
          state_nx = IDLE;
        end else begin
          ferr_set = 1'b1;
          state_nx = BREAK;
        end
      end
      BREAK: begin
        if (line_bit == IDLE_LEVEL) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Terminal-count down-counter: DATA lasts exactly DATA_BITS samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_left <= '0;
    end else if (sh_clear) begin
      bits_left <= CNT_LOAD;
    end else if (sh_shift && (bits_left != '0)) begin
      bits_left <= bits_left - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_pend  <= 1'b0;
      bus        <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (perr_cap) begin
        perr_pend <= line_bit ^ acc;
      end
      if (load) begin
        bus        <= shreg;
        parity_err <= perr_pend;
      end
      if (load) begin
        valid <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end
      // drop only happens while valid && !ready, so it never meets accept.
      if (drop) begin
        overrun <= 1'b1;
      end else if (accept) begin
        overrun <= 1'b0;
      end
      frame_err <= ferr_set;
    end
  end

endmodule

// File: tb/tb_serial_parity_receiver.sv
module tb_serial_parity_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] bus;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  serial_parity_receiver #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .bus       (bus),
    .valid     (valid),
    .ready     (ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit; it is sampled on the next rising edge. Returns 1 time unit
  // after that edge, so outputs registered on it are visible.
  task automatic send_bit(input logic b);
    data = b;
    @(posedge clk);
    #1;
  endtask

  // Full frame; optional ready pulse coinciding with the stop-bit edge.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input bit ready_on_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    if (ready_on_stop) ready = 1'b1;
    send_bit(stop);
    if (ready_on_stop) ready = 1'b0;
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return logic'($countones(b) % 2);
  endfunction

  task automatic accept_one();
    ready = 1'b1;
    send_bit(1'b1);
    ready = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rpar;
    logic       rstop;
    int         gap;

    // Reset state
    #2;
    chk("rst_bus", bus, 0);
    chk("rst_valid", valid, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);

    // 0xA5 with correct parity
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    chk("a5_bus", bus, 8'hA5);
    chk("a5_valid", valid, 1);
    chk("a5_perr", parity_err, 0);
    send_bit(1'b1);
    chk("a5_held", valid, 1);
    accept_one();
    chk("a5_accepted_valid", valid, 0);
    chk("a5_bus_kept", bus, 8'hA5);

    // 0x01 with wrong parity
    send_frame(8'h01, 1'b0, 1'b1, 0);
    chk("p01_bus", bus, 8'h01);
    chk("p01_valid", valid, 1);
    chk("p01_perr", parity_err, 1);
    accept_one();

    // 0x3C with bad stop, line held low, then 0x5A
    send_frame(8'h3C, good_par(8'h3C), 1'b0, 0);
    chk("fe_pulse", frame_err, 1);
    chk("fe_no_valid", valid, 0);
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b0);
      chk("brk_ferr", frame_err, 0);
      chk("brk_valid", valid, 0);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(8'h5A, good_par(8'h5A), 1'b1, 0);
    chk("after_brk_bus", bus, 8'h5A);
    chk("after_brk_valid", valid, 1);
    chk("after_brk_perr", parity_err, 0);
    accept_one();

    // Overrun: ready low, back-to-back 0x11 then 0x22
    send_frame(8'h11, good_par(8'h11), 1'b1, 0);
    chk("ovr_first_ovr", overrun, 0);
    send_frame(8'h22, good_par(8'h22), 1'b1, 0);
    chk("ovr_bus", bus, 8'h11);
    chk("ovr_valid", valid, 1);
    chk("ovr_flag", overrun, 1);
    accept_one();
    chk("ovr_clr_valid", valid, 0);
    chk("ovr_clr_flag", overrun, 0);

    // Simultaneous load and accept
    send_frame(8'h66, good_par(8'h66), 1'b1, 0);
    chk("sim_first", bus, 8'h66);
    send_frame(8'h77, good_par(8'h77), 1'b1, 1);
    chk("sim_bus", bus, 8'h77);
    chk("sim_valid", valid, 1);
    chk("sim_ovr", overrun, 0);
    accept_one();

    // Reset mid-frame with a byte pending
    send_frame(8'h99, good_par(8'h99), 1'b1, 0);
    chk("pre_rst_valid", valid, 1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    data = 1'b1;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_bus", bus, 0);
    chk("mid_rst_ovr", overrun, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    chk("post_rst_valid", valid, 0);
    chk("post_rst_ferr", frame_err, 0);
    send_frame(8'hC3, good_par(8'hC3), 1'b1, 0);
    chk("c3_bus", bus, 8'hC3);
    chk("c3_valid", valid, 1);
    chk("c3_perr", parity_err, 0);
    accept_one();

    // Randomized frames, consumer with ready tied high
    ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rb    = 8'($urandom_range(0, 255));
      rpar  = ($urandom_range(0, 3) == 0) ? ~good_par(rb) : good_par(rb);
      rstop = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
      send_frame(rb, rpar, rstop, 0);
      if (rstop) begin
        chk("rnd_valid", valid, 1);
        chk("rnd_bus", bus, rb);
        chk("rnd_perr", parity_err, logic'(rpar != good_par(rb)));
        chk("rnd_ferr", frame_err, 0);
      end else begin
        chk("rnd_fe_valid", valid, 0);
        chk("rnd_fe_pulse", frame_err, 1);
      end
      send_bit(1'b1);
      chk("rnd_one_cycle", valid, 0);
      chk("rnd_ovr", overrun, 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) send_bit(1'b1);
    end
    ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
